uart_reg_bridge: RTL and testbench
==================================

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 50000: maximum number of idle clocks allowed between bytes of one frame.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_done_tick_i, input, 1 bit: one-cycle pulse from the UART receiver meaning a byte is valid.
REQ-005 SHALL have port rx_data_i, input, 8 bits: received byte, valid while rx_done_tick_i is high.
REQ-006 SHALL have port tx_data_o, output, 8 bits: byte to transmit.
REQ-007 SHALL have port start_tx_o, output, 1 bit: one-cycle pulse that starts a UART transmit.
REQ-008 SHALL have port tx_done_tick_i, input, 1 bit: one-cycle pulse from the UART transmitter meaning the byte has been sent.
REQ-009 SHALL have port bus_req_o, output, 1 bit: register-bus request, held until acknowledged.
REQ-010 SHALL have port bus_we_o, output, 1 bit: 1 for a write access, 0 for a read access.
REQ-011 SHALL have port bus_addr_o, output, 8 bits: register address.
REQ-012 SHALL have port bus_wdata_o, output, 8 bits: write data.
REQ-013 SHALL have port bus_rdata_i, input, 8 bits: read data, valid while bus_ack_i is high.
REQ-014 SHALL have port bus_ack_i, input, 1 bit: one-cycle access-complete pulse from the register bus.
REQ-015 SHALL have port err_tick_o, output, 1 bit: one-cycle pulse on any frame error.

Function
REQ-016 SHALL implement an FSM with states IDLE, GET_ADDR, GET_DATA, GET_CSUM, BUS, SEND and WAIT_TX.
REQ-017 SHALL, in IDLE on receipt of byte 0x57 ('W'), go to GET_ADDR with write mode; on receipt of 0x52 ('R'), go to GET_ADDR with read mode.
REQ-018 SHALL, in IDLE on receipt of any other byte, load 0x15 (NAK) into tx_data_o, pulse err_tick_o, and go to SEND.
REQ-019 SHALL, in GET_ADDR, capture the byte into bus_addr_o; a write then goes to GET_DATA, a read goes to the final state of the frame (BUS, or GET_CSUM when the checksum is enabled).
REQ-020 SHALL, in GET_DATA, capture the byte into bus_wdata_o, then go to BUS (or GET_CSUM when the checksum is enabled).
REQ-021 SHALL assert bus_req_o in the cycle after the final frame byte's rx_done_tick_i.
REQ-022 SHALL hold bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o stable until bus_ack_i; bus_req_o SHALL deassert in the cycle after bus_ack_i.
REQ-023 SHALL, on bus_ack_i, load tx_data_o with 0x06 (ACK) for a write or with bus_rdata_i for a read, then go to SEND.
REQ-024 SHALL, in SEND, pulse start_tx_o for exactly one cycle and go to WAIT_TX.
REQ-025 SHALL start_tx_o one cycle after bus_ack_i, and one cycle after the rx_done_tick_i that triggers a NAK.
REQ-026 SHALL, in WAIT_TX on tx_done_tick_i, return to IDLE.
REQ-027 SHALL run an idle counter in GET_* states, sized $clog2(TimeoutCycles+1) bits, that clears on every rx_done_tick_i.
REQ-028 SHALL, when the idle counter reaches TimeoutCycles, pulse err_tick_o and return to IDLE without any bus access or transmit.
REQ-029 SHALL, when rx_done_tick_i coincides with the timeout cycle, accept the byte and not flag a timeout.
REQ-030 SHALL, on rx_done_tick_i in BUS, SEND or WAIT_TX, drop the byte, pulse err_tick_o, and leave the state unchanged.
REQ-031 SHALL ignore tx_done_tick_i outside WAIT_TX and bus_ack_i outside BUS.

Reset
REQ-032 SHALL, on rst_i, go to IDLE and clear tx_data_o, start_tx_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, err_tick_o, the idle counter and the checksum accumulator to 0.
REQ-033 SHALL, on rst_i mid-frame or mid-access, abandon the operation immediately: bus_req_o is 0 the next cycle and no start_tx_o pulse is emitted.

Configuration
REQ-034 SHALL, when macro UART_BRIDGE_CHECKSUM_EN is defined, require a trailing checksum byte equal to the XOR of all preceding frame bytes, received in GET_CSUM.
REQ-035 SHALL, with UART_BRIDGE_CHECKSUM_EN defined and a checksum mismatch, send NAK 0x15, pulse err_tick_o, and perform no bus access.
REQ-036 SHALL, without UART_BRIDGE_CHECKSUM_EN, omit GET_CSUM and the accumulator entirely, so frames carry no checksum byte.

Verification
REQ-037 SHALL cover: rx 0x57, 0x10, 0xA5 -> bus_req_o with we=1, addr=0x10, wdata=0xA5; ack -> start_tx_o with tx_data_o=0x06.
REQ-038 SHALL cover: rx 0x52, 0x20; bus_rdata_i=0x3C on ack -> start_tx_o one cycle later with tx_data_o=0x3C.
REQ-039 SHALL cover: rx 0x41 in IDLE -> err_tick_o, tx_data_o=0x15, no bus_req_o.
REQ-040 SHALL cover: rx 0x57, then silence for TimeoutCycles clocks -> err_tick_o, IDLE, no bus or tx activity; a following frame completes normally.
REQ-041 SHALL cover: rst_i while bus_req_o=1 -> bus_req_o=0 next cycle and a later bus_ack_i is ignored.
REQ-042 SHALL cover, with UART_BRIDGE_CHECKSUM_EN: rx 0x52, 0x20, 0x00 (expected checksum 0x72) -> NAK 0x15 with no bus access; rx 0x52, 0x20, 0x72 -> normal read.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// UART command frame to register-bus bridge: 'W' addr data / 'R' addr, answered with ACK, read data or NAK.
// Optional trailing XOR checksum byte when UART_BRIDGE_CHECKSUM_EN is defined.
module uart_reg_bridge #(
   parameter int unsigned TimeoutCycles = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_done_tick_i,
   input  logic [7:0] rx_data_i,
   output logic [7:0] tx_data_o,
   output logic       start_tx_o,
   input  logic       tx_done_tick_i,
   output logic       bus_req_o,
   output logic       bus_we_o,
   output logic [7:0] bus_addr_o,
   output logic [7:0] bus_wdata_o,
   input  logic [7:0] bus_rdata_i,
   input  logic       bus_ack_i,
   output logic       err_tick_o
);

   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [7:0] ChWrite = 8'h57;
   localparam logic [7:0] ChRead = 8'h52;
   localparam logic [7:0] ChAck = 8'h06;
   localparam logic [7:0] ChNak = 8'h15;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StGetAddr = 3'd1,
      StGetData = 3'd2,
`ifdef UART_BRIDGE_CHECKSUM_EN
      StGetCsum = 3'd3,
`endif
      StBus     = 3'd4,
      StSend    = 3'd5,
      StWaitTx  = 3'd6
   } state_e;

`ifdef UART_BRIDGE_CHECKSUM_EN
   localparam state_e StFrameEnd = StGetCsum;
`else
   localparam state_e StFrameEnd = StBus;
`endif

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            in_get;
`ifdef UART_BRIDGE_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         we_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         tx_data_q <= 8'h00;
         err_q     <= 1'b0;
         cnt_q     <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
         csum_q    <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_data_q <= tx_data_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_data_d = tx_data_q;
      err_d     = 1'b0;
      cnt_d     = '0;
      in_get    = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         StIdle: begin
            if (rx_done_tick_i) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d = rx_data_i;
`endif
               if (rx_data_i == ChWrite) begin
                  we_d    = 1'b1;
                  state_d = StGetAddr;
               end else if (rx_data_i == ChRead) begin
                  we_d    = 1'b0;
                  state_d = StGetAddr;
               end else begin
                  tx_data_d = ChNak;
                  err_d     = 1'b1;
                  state_d   = StSend;
               end
            end
         end
         StGetAddr: begin
            in_get = 1'b1;
            if (rx_done_tick_i) begin
               addr_d  = rx_data_i;
               state_d = we_q ? StGetData : StFrameEnd;
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d  = csum_q ^ rx_data_i;
`endif
            end
         end
         StGetData: begin
            in_get = 1'b1;
            if (rx_done_tick_i) begin
               wdata_d = rx_data_i;
               state_d = StFrameEnd;
`ifdef UART_BRIDGE_CHECKSUM_EN
               csum_d  = csum_q ^ rx_data_i;
`endif
            end
         end
`ifdef UART_BRIDGE_CHECKSUM_EN
         StGetCsum: begin
            in_get = 1'b1;
            if (rx_done_tick_i) begin
               if (rx_data_i == csum_q) begin
                  state_d = StBus;
               end else begin
                  tx_data_d = ChNak;
                  err_d     = 1'b1;
                  state_d   = StSend;
               end
            end
         end
`endif
         StBus: begin
            err_d = rx_done_tick_i;
            if (bus_ack_i) begin
               tx_data_d = we_q ? ChAck : bus_rdata_i;
               state_d   = StSend;
            end
         end
         StSend: begin
            err_d   = rx_done_tick_i;
            state_d = StWaitTx;
         end
         StWaitTx: begin
            err_d = rx_done_tick_i;
            if (tx_done_tick_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A byte arriving on the timeout cycle wins over the timeout.
      if (in_get && !rx_done_tick_i) begin
         if (cnt_q == CntMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end
   end

   always_comb begin
      bus_req_o   = (state_q == StBus);
      start_tx_o  = (state_q == StSend);
      bus_we_o    = we_q;
      bus_addr_o  = addr_q;
      bus_wdata_o = wdata_q;
      tx_data_o   = tx_data_q;
      err_tick_o  = err_q;
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed, table-driven bench for uart_reg_bridge; frames gain a checksum byte when
// UART_BRIDGE_CHECKSUM_EN is defined.
module tb_uart_reg_bridge;

   localparam int unsigned T = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data;
   logic       start_tx;
   logic       tx_done = 1'b0;
   logic       bus_req;
   logic       bus_we;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata = 8'h00;
   logic       bus_ack = 1'b0;
   logic       err_tick;

   int checks = 0;
   int errors = 0;

   uart_reg_bridge #(.TimeoutCycles(T)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_done_tick_i(rx_done),
      .rx_data_i     (rx_data),
      .tx_data_o     (tx_data),
      .start_tx_o    (start_tx),
      .tx_done_tick_i(tx_done),
      .bus_req_o     (bus_req),
      .bus_we_o      (bus_we),
      .bus_addr_o    (bus_addr),
      .bus_wdata_o   (bus_wdata),
      .bus_rdata_i   (bus_rdata),
      .bus_ack_i     (bus_ack),
      .err_tick_o    (err_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       is_nak;
      logic       exp_we;
      logic [7:0] exp_tx;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] wdata);
      logic [7:0] cs;
      cs = cmd ^ addr;
      send_byte(cmd);
      send_byte(addr);
      if (cmd == 8'h57) begin
         send_byte(wdata);
         cs = cs ^ wdata;
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(cs);
`endif
   endtask

   // Entered in SEND; walks through WAIT_TX back to IDLE.
   task automatic finish_tx();
      tick();
      chk1("start_tx_one_cycle", start_tx, 1'b0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic finish_access(input logic [7:0] rdata, input logic [7:0] exp_tx);
      bus_rdata = rdata;
      bus_ack   = 1'b1;
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      chk1("start_tx_after_ack", start_tx, 1'b1);
      chk1("bus_req_drop_after_ack", bus_req, 1'b0);
      chk8("tx_data_after_ack", tx_data, exp_tx);
      finish_tx();
   endtask

   initial begin
      vecs[0] = '{8'h57, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b1, 8'h06};
      vecs[1] = '{8'h52, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C};
      vecs[2] = '{8'h41, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h15};
      vecs[3] = '{8'h57, 8'hFF, 8'h00, 8'h77, 1'b0, 1'b1, 8'h06};
      vecs[4] = '{8'h52, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF};

      repeat (3) tick();
      rst = 1'b0;
      chk1("reset_bus_req", bus_req, 1'b0);
      chk1("reset_start_tx", start_tx, 1'b0);
      chk1("reset_err", err_tick, 1'b0);
      chk8("reset_tx_data", tx_data, 8'h00);
      chk8("reset_addr", bus_addr, 8'h00);
      chk8("reset_wdata", bus_wdata, 8'h00);
      chk1("reset_we", bus_we, 1'b0);
      tick();

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].is_nak) begin
            send_byte(vecs[i].cmd);
            chk1("nak_err", err_tick, 1'b1);
            chk1("nak_start_tx", start_tx, 1'b1);
            chk1("nak_no_bus_req", bus_req, 1'b0);
            chk8("nak_tx_data", tx_data, vecs[i].exp_tx);
            finish_tx();
         end else begin
            send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            chk1("vec_bus_req", bus_req, 1'b1);
            chk1("vec_we", bus_we, vecs[i].exp_we);
            chk8("vec_addr", bus_addr, vecs[i].addr);
            if (vecs[i].exp_we) chk8("vec_wdata", bus_wdata, vecs[i].wdata);
            repeat (2) tick();
            chk1("vec_bus_req_held", bus_req, 1'b1);
            chk8("vec_addr_held", bus_addr, vecs[i].addr);
            chk1("vec_no_start_before_ack", start_tx, 1'b0);
            finish_access(vecs[i].rdata, vecs[i].exp_tx);
         end
         tick();
      end

      // Timeout: T idle clocks allowed, the next idle clock aborts the frame.
      begin
         int errs_seen;
         int activity;
         send_byte(8'h57);
         repeat (T) tick();
         chk1("timeout_not_early", err_tick, 1'b0);
         tick();
         chk1("timeout_err", err_tick, 1'b1);
         errs_seen = 0;
         activity  = 0;
         for (int c = 0; c < 4; c++) begin
            if (bus_req || start_tx) activity++;
            if (err_tick) errs_seen++;
            tick();
         end
         chk8("timeout_no_activity", 8'(activity), 8'd0);
         chk8("timeout_single_err", 8'(errs_seen), 8'd1);
         send_frame(8'h57, 8'h10, 8'hA5);
         chk1("after_timeout_bus_req", bus_req, 1'b1);
         chk8("after_timeout_addr", bus_addr, 8'h10);
         finish_access(8'h00, 8'h06);
         tick();
      end

      // Byte arriving exactly on the timeout cycle is accepted.
      send_byte(8'h57);
      repeat (T) tick();
      send_byte(8'h33);
      chk1("edge_byte_no_err", err_tick, 1'b0);
      send_byte(8'h44);
`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(8'h57 ^ 8'h33 ^ 8'h44);
`endif
      chk1("edge_bus_req", bus_req, 1'b1);
      chk8("edge_addr", bus_addr, 8'h33);
      chk8("edge_wdata", bus_wdata, 8'h44);
      finish_access(8'h00, 8'h06);
      tick();

      // Stray byte during BUS is dropped with an error, access continues.
      send_frame(8'h52, 8'h20, 8'h00);
      send_byte(8'h99);
      chk1("stray_err", err_tick, 1'b1);
      chk1("stray_bus_req_held", bus_req, 1'b1);
      chk8("stray_addr_held", bus_addr, 8'h20);
      finish_access(8'h5A, 8'h5A);
      tick();

      // Reset mid-access abandons the access; a late ack is ignored.
      send_frame(8'h57, 8'h10, 8'hA5);
      chk1("rst_pre_bus_req", bus_req, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rst_bus_req_low", bus_req, 1'b0);
      chk8("rst_addr_clear", bus_addr, 8'h00);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk1("rst_late_ack_no_tx", start_tx, 1'b0);
      chk1("rst_late_ack_no_req", bus_req, 1'b0);
      chk8("rst_tx_data_clear", tx_data, 8'h00);
      tick();

`ifdef UART_BRIDGE_CHECKSUM_EN
      send_byte(8'h52);
      send_byte(8'h20);
      send_byte(8'h00);
      chk1("csum_bad_err", err_tick, 1'b1);
      chk1("csum_bad_start_tx", start_tx, 1'b1);
      chk1("csum_bad_no_bus", bus_req, 1'b0);
      chk8("csum_bad_nak", tx_data, 8'h15);
      finish_tx();
      tick();
      send_byte(8'h52);
      send_byte(8'h20);
      send_byte(8'h72);
      chk1("csum_ok_bus_req", bus_req, 1'b1);
      chk8("csum_ok_addr", bus_addr, 8'h20);
      finish_access(8'hC3, 8'hC3);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
